// File: rtl/lc3_pkg.sv
// Shared LC3 decode definitions: opcode enum, control-word encodings and the
// E_Control field layout used by Decode, Execute and Writeback.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_t;

    // alu_control encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    // pcselect1 (address offset source) encodings
    localparam logic [1:0] PCSEL1_NONE = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO = 2'b11;

    // W_Control (writeback source) encodings
    localparam logic [1:0] WCTL_ALU   = 2'b00;
    localparam logic [1:0] WCTL_PCREL = 2'b01;
    localparam logic [1:0] WCTL_MEM   = 2'b10;

    // E_Control field positions
    localparam int E_W          = 6;
    localparam int E_ALU_MSB    = 5;
    localparam int E_ALU_LSB    = 4;
    localparam int E_PCSEL1_MSB = 3;
    localparam int E_PCSEL1_LSB = 2;
    localparam int E_PCSEL2     = 1;
    localparam int E_OP2SEL     = 0;

    // Assemble an E_Control word from its fields
    function automatic logic [E_W-1:0] packEControl(
        input logic [1:0] aluControl,
        input logic [1:0] pcSelect1,
        input logic       pcSelect2,
        input logic       op2Select
    );
        logic [E_W-1:0] word;
        word                           = '0;
        word[E_ALU_MSB:E_ALU_LSB]       = aluControl;
        word[E_PCSEL1_MSB:E_PCSEL1_LSB] = pcSelect1;
        word[E_PCSEL2]                  = pcSelect2;
        word[E_OP2SEL]                  = op2Select;
        return word;
    endfunction

endpackage

// File: rtl/lc3_decode_if.sv
// Decode-stage bus: capture strobe, instruction/npc from Fetch, and the
// registered instruction plus control words presented to later stages.
interface lc3_decode_if #(parameter int DATA_W = 16) ();
    logic              enable_decode;
    logic [DATA_W-1:0] Instr_dout;
    logic [DATA_W-1:0] npc_in;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] npc_out;
    logic [5:0]        E_Control;
    logic [1:0]        W_Control;
    logic              Mem_Control;
    logic              decode_valid;
    logic              illegal_instr;

    // Controller / Fetch side
    modport master (
        output enable_decode, Instr_dout, npc_in,
        input  IR, npc_out, E_Control, W_Control, Mem_Control,
               decode_valid, illegal_instr
    );

    // Decode stage side
    modport slave (
        input  enable_decode, Instr_dout, npc_in,
        output IR, npc_out, E_Control, W_Control, Mem_Control,
               decode_valid, illegal_instr
    );
endinterface

// File: rtl/lc3_ctrl_lut.sv
// Combinational control lookup: opcode plus IR[5] to execute, writeback and
// memory control words, and an illegal flag for unimplemented opcodes.
module lc3_ctrl_lut
    import lc3_pkg::*;
(
    input  logic [3:0]     opcode,
    input  logic           immMode,
    output logic [E_W-1:0] eControl,
    output logic [1:0]     wControl,
    output logic           memControl,
    output logic           illegal
);
    opcode_t op;
    assign op = opcode_t'(opcode);

    // Per-opcode control decode; unimplemented opcodes leave every control at 0
    always_comb begin
        eControl   = '0;
        wControl   = WCTL_ALU;
        memControl = 1'b0;
        illegal    = 1'b0;
        case (op)
            OP_ADD: eControl = packEControl(ALU_ADD, PCSEL1_NONE, 1'b0, ~immMode);
            OP_AND: eControl = packEControl(ALU_AND, PCSEL1_NONE, 1'b0, ~immMode);
            OP_NOT: eControl = packEControl(ALU_NOT, PCSEL1_NONE, 1'b0, 1'b1);
            OP_LD: begin
                eControl = packEControl(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                wControl = WCTL_MEM;
            end
            OP_LDR: begin
                eControl = packEControl(ALU_ADD, PCSEL1_OFF6, 1'b0, 1'b0);
                wControl = WCTL_MEM;
            end
            OP_LDI: begin
                eControl   = packEControl(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                wControl   = WCTL_MEM;
                memControl = 1'b1;
            end
            OP_LEA: begin
                eControl = packEControl(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                wControl = WCTL_PCREL;
            end
            OP_ST:  eControl = packEControl(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
            OP_STR: eControl = packEControl(ALU_ADD, PCSEL1_OFF6, 1'b0, 1'b0);
            OP_STI: begin
                eControl   = packEControl(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                memControl = 1'b1;
            end
            OP_BR:  eControl = packEControl(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
            OP_JMP: eControl = packEControl(ALU_ADD, PCSEL1_ZERO, 1'b0, 1'b0);
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/lc3_decode.sv
// LC3 decode stage: captures the fetched instruction and npc on enable and
// registers the control words produced by lc3_ctrl_lut.
module lc3_decode
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    lc3_decode_if.slave  dif
);
    logic [E_W-1:0]    eControlLut;
    logic [1:0]        wControlLut;
    logic              memControlLut;
    logic              illegalLut;

    logic [DATA_W-1:0] ir_p1;
    logic [DATA_W-1:0] npc_p1;
    logic [E_W-1:0]    eControl_p1;
    logic [1:0]        wControl_p1;
    logic              memControl_p1;
    logic              vld_p1;
    logic              illegal_p1;

    lc3_ctrl_lut ctrlLut (
        .opcode     (dif.Instr_dout[DATA_W-1 -: 4]),
        .immMode    (dif.Instr_dout[5]),
        .eControl   (eControlLut),
        .wControl   (wControlLut),
        .memControl (memControlLut),
        .illegal    (illegalLut)
    );

    // Capture stage: data and controls hold when not enabled, valid/illegal pulse per capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_p1         <= '0;
            npc_p1        <= '0;
            eControl_p1   <= '0;
            wControl_p1   <= '0;
            memControl_p1 <= 1'b0;
            vld_p1        <= 1'b0;
            illegal_p1    <= 1'b0;
        end else begin
            vld_p1     <= dif.enable_decode;
            illegal_p1 <= dif.enable_decode & illegalLut;
            if (dif.enable_decode) begin
                ir_p1         <= dif.Instr_dout;
                npc_p1        <= dif.npc_in;
                eControl_p1   <= eControlLut;
                wControl_p1   <= wControlLut;
                memControl_p1 <= memControlLut;
            end
        end
    end

    assign dif.IR            = ir_p1;
    assign dif.npc_out       = npc_p1;
    assign dif.E_Control     = eControl_p1;
    assign dif.W_Control     = wControl_p1;
    assign dif.Mem_Control   = memControl_p1;
    assign dif.decode_valid  = vld_p1;
    assign dif.illegal_instr = illegal_p1;
endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode: directed instructions with hand-computed
// control words are queued at issue; a negedge monitor checks every cycle.
module tb_lc3_decode;
    logic clk;
    logic rst;

    lc3_decode_if #(.DATA_W(16)) dif ();

    lc3_decode #(.DATA_W(16)) dut (
        .clock (clk),
        .reset (rst),
        .dif   (dif)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [42:0] act, input logic [42:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got IR/npc/E/W/M/vld/ill=%h required %h", name, act, req);
        end
    endtask

    function automatic logic [42:0] pack(input exp_t x, input logic vld);
        return {x.ir, x.npc, x.e, x.w, x.m, vld, x.ill};
    endfunction

    // Monitor: compares outputs every cycle against reset, queued or held expectations
    always @(negedge clk) begin
        logic [42:0] act;
        exp_t        e;
        act = {dif.IR, dif.npc_out, dif.E_Control, dif.W_Control, dif.Mem_Control,
               dif.decode_valid, dif.illegal_instr};
        if (rst) begin
            held = '{16'h0, 16'h0, 6'h0, 2'h0, 1'b0, 1'b0};
            check("reset", act, pack(held, 1'b0));
        end else if (dif.decode_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", act, 43'h0);
            end else begin
                e = sb.pop_front();
                check($sformatf("decode_%h", e.ir), act, pack(e, 1'b1));
                held = e;
                held.ill = 1'b0;
            end
        end else begin
            check("hold", act, pack(held, 1'b0));
        end
    end

    task automatic issue(input logic [15:0] instr, input logic [15:0] npc,
                         input logic [5:0] e, input logic [1:0] w,
                         input logic m, input logic ill);
        exp_t x;
        @(posedge clk);
        #1;
        dif.enable_decode = 1'b1;
        dif.Instr_dout    = instr;
        dif.npc_in        = npc;
        x = '{instr, npc, e, w, m, ill};
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dif.enable_decode = 1'b0;
            dif.Instr_dout    = 16'($urandom);
            dif.npc_in        = 16'($urandom);
        end
    endtask

    initial begin
        held = '{16'h0, 16'h0, 6'h0, 2'h0, 1'b0, 1'b0};
        rst = 1'b1;
        dif.enable_decode = 1'b0;
        dif.Instr_dout    = 16'h0;
        dif.npc_in        = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // First enable after reset, then back-to-back ALU ops
        issue(16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0);
        issue(16'h12A5, 16'h3002, 6'b000000, 2'b00, 1'b0, 1'b0);
        issue(16'h5283, 16'h3003, 6'b010001, 2'b00, 1'b0, 1'b0);
        issue(16'h5025, 16'h3004, 6'b010000, 2'b00, 1'b0, 1'b0);
        issue(16'h903F, 16'h3005, 6'b100001, 2'b00, 1'b0, 1'b0);
        // Loads and stores
        issue(16'hA205, 16'h3006, 6'b000110, 2'b10, 1'b1, 1'b0);
        issue(16'h6285, 16'h3007, 6'b001000, 2'b10, 1'b0, 1'b0);
        issue(16'h2000, 16'h3008, 6'b000110, 2'b10, 1'b0, 1'b0);
        issue(16'h3200, 16'h3009, 6'b000110, 2'b00, 1'b0, 1'b0);
        issue(16'h7285, 16'h300A, 6'b001000, 2'b00, 1'b0, 1'b0);
        issue(16'hB000, 16'h300B, 6'b000110, 2'b00, 1'b1, 1'b0);
        issue(16'hC080, 16'h300C, 6'b001100, 2'b00, 1'b0, 1'b0);
        // LEA then a 3-cycle stall with changing inputs
        issue(16'hE3FF, 16'h300D, 6'b000110, 2'b01, 1'b0, 1'b0);
        idle(3);
        // Unimplemented opcodes, then BR
        issue(16'hD000, 16'h4000, 6'b000000, 2'b00, 1'b0, 1'b1);
        issue(16'h0000, 16'h4001, 6'b000110, 2'b00, 1'b0, 1'b0);
        issue(16'h4000, 16'h4002, 6'b000000, 2'b00, 1'b0, 1'b1);
        issue(16'h8000, 16'h4003, 6'b000000, 2'b00, 1'b0, 1'b1);
        issue(16'hF025, 16'h4004, 6'b000000, 2'b00, 1'b0, 1'b1);
        idle(2);
        // Asynchronous reset between edges while IR holds LDI
        issue(16'hA205, 16'h5000, 6'b000110, 2'b10, 1'b1, 1'b0);
        idle(1);
        @(posedge clk);
        #2 rst = 1'b1;
        #6 rst = 1'b0;
        // Decode resumes immediately after reset
        issue(16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected decodes never presented, required 0", sb.size());
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lc3_decode.md
# lc3_decode

Decode stage of the LC3 pipeline, directly downstream of Fetch. It samples the instruction word returned from instruction memory together with Fetch's next-PC value. It registers both, and produces the execute, writeback and memory control words consumed by Execute, Writeback and the memory-access controller. It also flags unimplemented opcodes so the testbench can probe them alongside the Fetch signals.

## Interface
Parameters:
- DATA_W, 16, instruction and PC width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable_decode  in  1  capture strobe from the controller; instruction and npc are sampled only when high.
- Instr_dout  in  16  instruction word from instruction memory.
- npc_in  in  16  PC+1 from Fetch, aligned with Instr_dout.
- IR  out  16  registered instruction.
- npc_out  out  16  registered npc_in.
- E_Control  out  6  execute control: [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select.
- W_Control  out  2  writeback select.
- Mem_Control  out  1  indirect memory access (LDI/STI).
- decode_valid  out  1  outputs hold a freshly decoded instruction this cycle.
- illegal_instr  out  1  one-cycle pulse when the decoded opcode is unimplemented.

## Operation
- Opcode = Instr_dout[15:12]. Implemented opcodes: ADD 0001, AND 0101, NOT 1001, LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011, BR 0000, JMP 1100.
- alu_control: ADD=00, AND=01, NOT=10; all other opcodes 00.
- pcselect1 (offset select): offset9=01 for BR/LD/LDI/ST/STI/LEA; offset6=10 for LDR/STR; zero=11 for JMP; 00 for ALU ops.
- pcselect2: 1 (npc base) for BR/LD/LDI/ST/STI/LEA; 0 (BaseR) otherwise.
- op2select: ADD/AND with IR[5]=0 → 1 (SR2); ADD/AND with IR[5]=1 → 0 (imm5); NOT → 1; all others 0.
- W_Control: 00 ALU result (ADD/AND/NOT), 01 PC-relative address (LEA), 10 memory data (LD/LDR/LDI), 00 for ST/STR/STI/BR/JMP.
- Mem_Control: 1 for LDI and STI only.
- Unimplemented opcodes (0100, 1000, 1101, 1111):
  - IR and npc_out still capture the incoming values.
  - E_Control, W_Control and Mem_Control are all 0.
  - illegal_instr pulses.
- Control outputs are decoded from Instr_dout and registered; they are never combinational from the inputs.

## Timing
- Reset values: IR=0x0000, npc_out=0x0000, E_Control=0, W_Control=0, Mem_Control=0, decode_valid=0, illegal_instr=0.
- Latency: Instr_dout and npc_in sampled at edge N with enable_decode=1 → all outputs valid after edge N.
- decode_valid is enable_decode registered, giving one cycle of latency.
- illegal_instr is high only in the cycle after the capturing edge. It is 0 whenever decode_valid is 0.
- enable_decode=0: IR, npc_out and all control outputs hold their previous values. decode_valid and illegal_instr go to 0 at the next edge.
- Back-to-back enables: a new instruction is decoded every cycle. There are no bubbles.
- Reset asserted mid-stream: all outputs clear asynchronously, without waiting for a clock edge.
- First enable after reset deassertion decodes normally; there is no warm-up cycle.

## Structure
- Shared package lc3_pkg holds:
  - the opcode enum;
  - the alu_control, pcselect1 and W_Control encodings as named constants;
  - the E_Control field positions.
- Execute and Writeback import the same package.
- One combinational sub-module, lc3_ctrl_lut, maps opcode and IR[5] to {E_Control, W_Control, Mem_Control, illegal}.
- lc3_decode wraps lc3_ctrl_lut with the capture registers.

## Test plan
- Reset, then enable_decode=1 with Instr_dout=0x1283 (ADD R1,R2,R3), npc_in=0x3001 → next cycle: IR=0x1283, npc_out=0x3001, E_Control=000001, W_Control=00, Mem_Control=0, decode_valid=1.
- Instr_dout=0x12A5 (ADD immediate), then 0x5283 (AND register) back-to-back → E_Control=000000 then 010001, one per cycle.
- Instr_dout=0xA205 (LDI) → E_Control=000110, W_Control=10, Mem_Control=1. Instr_dout=0x6285 (LDR) → E_Control=001000, W_Control=10, Mem_Control=0.
- Decode 0xE3FF (LEA), then hold enable_decode=0 for 3 cycles with changing Instr_dout → outputs stay IR=0xE3FF, E_Control=000110, W_Control=01; decode_valid=0.
- Instr_dout=0xD000 (unimplemented) → controls all 0, illegal_instr=1 for exactly one cycle. A following 0x0000 (BR) gives illegal_instr=0 and E_Control=000110.
- Assert reset between edges while IR=0xA205 → IR, controls and decode_valid are 0 before the next rising edge.
